// File: rtl/timer_cmp_irq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : timer_cmp_irq_pkg
// Brief  : Shared timer compare definitions: reset value, register map and
//          control/status bit positions.
// Rev    : 1.0  initial release
// ============================================================================
package timer_cmp_irq_pkg;

    localparam logic [63:0] TCMP_RST_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

    // Register offsets within the timer APB window
    localparam logic [7:0] TCMP0_OFS = 8'h00;
    localparam logic [7:0] TCMP1_OFS = 8'h04;
    localparam logic [7:0] TIER_OFS  = 8'h08;
    localparam logic [7:0] TISR_OFS  = 8'h0C;

    localparam int unsigned INT_EN_BIT = 0;
    localparam int unsigned INT_ST_BIT = 0;

    // Expands the APB byte strobes into a 32-bit bit-enable mask
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage : timer_cmp_irq_pkg
`default_nettype wire

// File: rtl/timer_cmp_irq_byte_wr_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : byte_wr_reg
// Brief  : 32-bit register with per-byte strobed writes and reset value.
// Rev    : 1.0  initial release
// ============================================================================
module byte_wr_reg
    import timer_cmp_irq_pkg::*;
#(
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        i_wr_en,
    input  logic [3:0]  i_pstrb,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_q
);

    logic [31:0] r_q;
    logic [31:0] w_mask;

    assign w_mask = strb_mask(i_pstrb);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_q <= RST_VAL;
        end else if (i_wr_en) begin
            r_q <= (r_q & ~w_mask) | (i_wdata & w_mask);
        end
    end

    assign o_q = r_q;

endmodule : byte_wr_reg
`default_nettype wire

// File: rtl/timer_cmp_irq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : timer_cmp_irq
// Brief  : 64-bit timer compare with sticky status and maskable interrupt.
// Rev    : 1.0  initial release
// ============================================================================
module timer_cmp_irq
    import timer_cmp_irq_pkg::*;
#(
    parameter logic [63:0] TCMP_RST_VAL = TCMP_RST_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [63:0] cnt,
    input  logic [3:0]  pstrb,
    input  logic [31:0] wdata,
    input  logic        tcmp0_wr_sel,
    input  logic        tcmp1_wr_sel,
    input  logic        tier_wr_sel,
    input  logic        tisr_wr_sel,
    output logic [63:0] tcmp,
    output logic        int_en,
    output logic        int_st,
    output logic        tim_int
);

    logic w_sel_tcmp0;
    logic w_sel_tcmp1;
    logic w_sel_tier;
    logic w_sel_tisr;
    logic w_match;
    logic w_clr;
    logic r_int_en;
    logic r_int_st;

    // Overlapping selects resolve by fixed priority; losers are dropped
    assign w_sel_tcmp0 = tcmp0_wr_sel;
    assign w_sel_tcmp1 = tcmp1_wr_sel & ~tcmp0_wr_sel;
    assign w_sel_tier  = tier_wr_sel  & ~tcmp0_wr_sel & ~tcmp1_wr_sel;
    assign w_sel_tisr  = tisr_wr_sel  & ~tcmp0_wr_sel & ~tcmp1_wr_sel & ~tier_wr_sel;

    byte_wr_reg #(
        .RST_VAL (TCMP_RST_VAL[31:0])
    ) u_tcmp_lo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_wr_en   (w_sel_tcmp0),
        .i_pstrb   (pstrb),
        .i_wdata   (wdata),
        .o_q       (tcmp[31:0])
    );

    byte_wr_reg #(
        .RST_VAL (TCMP_RST_VAL[63:32])
    ) u_tcmp_hi (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_wr_en   (w_sel_tcmp1),
        .i_pstrb   (pstrb),
        .i_wdata   (wdata),
        .o_q       (tcmp[63:32])
    );

    assign w_match = (cnt == tcmp);
    assign w_clr   = w_sel_tisr & pstrb[0] & wdata[INT_ST_BIT];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_int_en <= 1'b0;
        end else if (w_sel_tier && pstrb[0]) begin
            r_int_en <= wdata[INT_EN_BIT];
        end
    end

    // A live match outranks a W1C so a stopped counter keeps status asserted
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_int_st <= 1'b0;
        end else if (w_match) begin
            r_int_st <= 1'b1;
        end else if (w_clr) begin
            r_int_st <= 1'b0;
        end
    end

    assign int_en  = r_int_en;
    assign int_st  = r_int_st;
    assign tim_int = r_int_en & r_int_st;

endmodule : timer_cmp_irq
`default_nettype wire

// File: tb/tb_timer_cmp_irq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_timer_cmp_irq
// Brief  : Scoreboard bench for timer_cmp_irq with a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_timer_cmp_irq;

    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [63:0] cnt       = '0;
    logic [3:0]  pstrb     = '0;
    logic [31:0] wdata     = '0;
    logic        tcmp0_wr_sel = 1'b0;
    logic        tcmp1_wr_sel = 1'b0;
    logic        tier_wr_sel  = 1'b0;
    logic        tisr_wr_sel  = 1'b0;
    logic [63:0] tcmp;
    logic        int_en;
    logic        int_st;
    logic        tim_int;

    timer_cmp_irq #(
        .TCMP_RST_VAL (ALL_ONES)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .cnt          (cnt),
        .pstrb        (pstrb),
        .wdata        (wdata),
        .tcmp0_wr_sel (tcmp0_wr_sel),
        .tcmp1_wr_sel (tcmp1_wr_sel),
        .tier_wr_sel  (tier_wr_sel),
        .tisr_wr_sel  (tisr_wr_sel),
        .tcmp         (tcmp),
        .int_en       (int_en),
        .int_st       (int_st),
        .tim_int      (tim_int)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [63:0] tcmp;
        logic        en;
        logic        st;
        logic        irq;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    logic [63:0] m_tcmp = ALL_ONES;
    logic        m_en   = 1'b0;
    logic        m_st   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] p,
                                          input logic [31:0] w);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (p[b]) r[8*b +: 8] = w[8*b +: 8];
        end
        return r;
    endfunction

    // Reference behaviour of one clock edge, using the inputs present at it
    task automatic model_edge();
        logic match;
        logic clr;
        if (!sys_rst_n) begin
            m_tcmp = ALL_ONES;
            m_en   = 1'b0;
            m_st   = 1'b0;
        end else begin
            match = (cnt == m_tcmp);
            clr   = 1'b0;
            if (tcmp0_wr_sel)      m_tcmp[31:0]  = merge(m_tcmp[31:0], pstrb, wdata);
            else if (tcmp1_wr_sel) m_tcmp[63:32] = merge(m_tcmp[63:32], pstrb, wdata);
            else if (tier_wr_sel) begin
                if (pstrb[0]) m_en = wdata[0];
            end
            else if (tisr_wr_sel)  clr = pstrb[0] & wdata[0];
            if (match)    m_st = 1'b1;
            else if (clr) m_st = 1'b0;
        end
        q.push_back(exp_t'{m_tcmp, m_en, m_st, m_en & m_st});
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        model_edge();
    endtask

    // sel = {tcmp0, tcmp1, tier, tisr}
    task automatic cyc(input logic [3:0] sel, input logic [3:0] p, input logic [31:0] w,
                       input logic [63:0] c);
        {tcmp0_wr_sel, tcmp1_wr_sel, tier_wr_sel, tisr_wr_sel} = sel;
        pstrb = p;
        wdata = w;
        cnt   = c;
        step();
    endtask

    always @(negedge sys_clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("sb_tcmp",    tcmp,    mon_e.tcmp);
            chk("sb_int_en",  {63'd0, int_en},  {63'd0, mon_e.en});
            chk("sb_int_st",  {63'd0, int_st},  {63'd0, mon_e.st});
            chk("sb_tim_int", {63'd0, tim_int}, {63'd0, mon_e.irq});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] c;
        logic [3:0]  sel;

        repeat (3) cyc(4'h0, 4'h0, 32'h0, 64'h0);
        chk("rst_tcmp",    tcmp, ALL_ONES);
        chk("rst_int_en",  {63'd0, int_en},  64'd0);
        chk("rst_int_st",  {63'd0, int_st},  64'd0);
        chk("rst_tim_int", {63'd0, tim_int}, 64'd0);
        sys_rst_n = 1'b1;

        cyc(4'b0100, 4'b0101, 32'hAABB_CCDD, 64'h0);
        chk("tcmp1_strobe", {32'd0, tcmp[63:32]}, 64'h0000_0000_FFBB_FFDD);

        cyc(4'b1000, 4'hF, 32'h0000_0010, 64'h0);
        cyc(4'b0100, 4'hF, 32'h0000_0000, 64'h0);
        cyc(4'b0010, 4'h1, 32'h1, 64'h0);
        for (int i = 0; i <= 16'h14; i++) begin
            cyc(4'h0, 4'h0, 32'h0, 64'(i));
            if (i == 16'hF)  chk("irq_before_match", {63'd0, tim_int}, 64'd0);
            if (i == 16'h10) chk("irq_after_match",  {63'd0, tim_int}, 64'd1);
        end

        cyc(4'b0001, 4'h1, 32'h1, 64'h15);
        chk("w1c_clear", {63'd0, int_st}, 64'd0);
        cyc(4'b0001, 4'h1, 32'h0, 64'h0F);
        cyc(4'b0001, 4'h1, 32'h1, 64'h10);
        chk("set_beats_clear", {63'd0, int_st}, 64'd1);
        cyc(4'b0001, 4'h1, 32'h1, 64'h10);
        chk("stopped_cnt_hold", {63'd0, int_st}, 64'd1);

        cyc(4'b0001, 4'h1, 32'h1, 64'h12);
        cyc(4'b0010, 4'h1, 32'h0, 64'h13);
        cyc(4'h0, 4'h0, 32'h0, 64'h10);
        chk("masked_st", {63'd0, int_st}, 64'd1);
        chk("masked_irq", {63'd0, tim_int}, 64'd0);
        cyc(4'b0010, 4'h1, 32'h1, 64'h11);
        chk("unmask_irq", {63'd0, tim_int}, 64'd1);

        cyc(4'b0001, 4'h1, 32'h1, 64'h30);
        cyc(4'b1000, 4'hF, 32'h30, 64'h30);
        chk("wr_eq_cnt_first", {63'd0, int_st}, 64'd0);
        cyc(4'h0, 4'h0, 32'h0, 64'h30);
        chk("wr_eq_cnt_next", {63'd0, int_st}, 64'd1);
        cyc(4'b1111, 4'hF, 32'h40, 64'h31);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       c = m_tcmp;
                1:       c = m_tcmp - 64'($urandom_range(0, 3));
                2:       c = cnt + 64'd1;
                default: c = {$urandom, $urandom};
            endcase
            sel = ($urandom_range(0, 7) < 3) ? 4'($urandom) : 4'h0;
            cyc(sel, 4'($urandom), $urandom, c);
        end

        cyc(4'b1000, 4'hF, 32'hFFFF_FFFF, 64'h5);
        cyc(4'b0100, 4'hF, 32'hFFFF_FFFF, 64'h5);
        cyc(4'b0001, 4'h1, 32'h1, 64'h5);
        chk("wrap_pre_clear", {63'd0, int_st}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(4'h0, 4'h0, 32'h0, ALL_ONES - 64'd3 + 64'(i));
        end
        chk("wrap_set", {63'd0, int_st}, 64'd1);
        cyc(4'b0010, 4'h1, 32'h1, 64'h5);
        chk("wrap_irq", {63'd0, tim_int}, 64'd1);

        #6;
        sys_rst_n = 1'b0;
        #1;
        chk("async_tcmp",    tcmp, ALL_ONES);
        chk("async_int_en",  {63'd0, int_en},  64'd0);
        chk("async_int_st",  {63'd0, int_st},  64'd0);
        chk("async_tim_int", {63'd0, tim_int}, 64'd0);
        m_tcmp = ALL_ONES;
        m_en   = 1'b0;
        m_st   = 1'b0;
        repeat (2) cyc(4'h0, 4'h0, 32'h0, 64'h0);
        sys_rst_n = 1'b1;
        repeat (3) cyc(4'h0, 4'h0, 32'h0, 64'h1);

        repeat (4) @(negedge sys_clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_timer_cmp_irq
`default_nettype wire
